// File: rtl/genius_msg_pkg.sv
// Shared definitions for the Genius 7-segment message path: message codes
// understood by the decoder, the queued request entry and the sequencer states.
package genius_msg_pkg;

    localparam logic [3:0] MSG_OFF     = 4'd0;
    localparam logic [3:0] MSG_DIF1    = 4'd1;
    localparam logic [3:0] MSG_DIF2    = 4'd2;
    localparam logic [3:0] MSG_DIF3    = 4'd3;
    localparam logic [3:0] MSG_VEL1    = 4'd4;
    localparam logic [3:0] MSG_VEL2    = 4'd5;
    localparam logic [3:0] MSG_PC      = 4'd6;
    localparam logic [3:0] MSG_PVP     = 4'd7;
    localparam logic [3:0] MSG_ERRO    = 4'd8;
    localparam logic [3:0] MSG_SUSS    = 4'd9;
    localparam logic [3:0] MSG_DIGI    = 4'd10;
    localparam logic [3:0] MSG_RESP    = 4'd11;
    localparam logic [3:0] MSG_ALL     = 4'd12;
    localparam logic [3:0] MSG_BLANK   = 4'd13;
    localparam logic [3:0] MSG_CONT    = 4'd14;
    localparam logic [3:0] MSG_INVALID = 4'd15;

    localparam int MSG_ENTRY_W = 6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [3:0] code;
        logic       blink;
        logic       sticky;
    } msg_entry_t;

    // Map the one undefined code onto blank so the decoder never sees it.
    function automatic logic [3:0] msg_safe_code(input logic [3:0] code);
        logic [3:0] res;
        if (code == MSG_INVALID) begin
            res = MSG_BLANK;
        end else begin
            res = code;
        end
        return res;
    endfunction

endpackage

// File: rtl/genius_msg_fifo.sv
// Small synchronous show-ahead FIFO with occupancy output. A push into a full
// queue is taken only when a pop happens in the same cycle; clr wins over both.
module genius_msg_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (level_r == (AW+1)'(0));
    assign full      = (level_r == LEVEL_FULL);
    assign level     = level_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage array: written on an accepted push, cleared on reset/clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Read/write pointers and occupancy; push+pop together leaves level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= (AW+1)'(0);
        end else if (clr) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/genius_msg_sequencer.sv
// Queues message requests from game control and shows each on the 7-segment
// decoder for HOLD_CYCLES, optionally blinking; falls back to the idle code or
// to the last sticky message when nothing is queued.
module genius_msg_sequencer
    import genius_msg_pkg::*;
#(
    parameter int         HOLD_CYCLES  = 50_000_000,
    parameter int         BLINK_CYCLES = 12_500_000,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [3:0] IDLE_CODE    = 4'd13
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [3:0]                    req_code,
    input  logic                          req_blink,
    input  logic                          req_sticky,
    input  logic                          flush,
    output logic [3:0]                    msg_code,
    output logic                          busy,
    output logic                          bad_code,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    seq_state_t        state_r;
    seq_state_t        state_nxt_s;
    msg_entry_t        cur_r;
    msg_entry_t        fifo_wdata_s;
    msg_entry_t        fifo_rdata_s;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic              phase_on_r;
    logic              sticky_valid_r;
    logic [3:0]        sticky_code_r;
    logic [3:0]        msg_code_r;
    logic              busy_r;
    logic              bad_code_r;
    logic [3:0]        msg_code_s;
    logic              handshake_s;
    logic              push_s;
    logic              pop_s;
    logic              sticky_set_s;
    logic              sticky_clr_s;
    logic              hold_done_s;
    logic              blink_done_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    assign req_ready    = !fifo_full_s;
    assign handshake_s  = req_valid && req_ready;
    // Code 15 is handshaken but never enters the queue; flush drops any push.
    assign push_s       = handshake_s && !flush && (req_code != MSG_INVALID);
    assign fifo_wdata_s = '{code: req_code, blink: req_blink, sticky: req_sticky};
    assign hold_done_s  = (hold_cnt_r == HOLD_LAST);
    assign blink_done_s = (blink_cnt_r == BLINK_LAST);

    assign msg_code = msg_code_r;
    assign busy     = busy_r;
    assign bad_code = bad_code_r;

    genius_msg_fifo #(
        .WIDTH (MSG_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (fifo_wdata_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (level)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: leave IDLE on a queued entry, leave SHOW on an expired hold with nothing queued.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        state_nxt_s = ST_SHOW;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SHOW: begin
                    if (hold_done_s && fifo_empty_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_SHOW;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: pop requests, sticky updates and the code to present next cycle.
    always_comb begin
        pop_s        = 1'b0;
        sticky_set_s = 1'b0;
        sticky_clr_s = 1'b0;
        msg_code_s   = IDLE_CODE;
        case (state_r)
            ST_IDLE: begin
                if (sticky_valid_r) begin
                    msg_code_s = sticky_code_r;
                end else begin
                    msg_code_s = IDLE_CODE;
                end
                if (!fifo_empty_s && !flush) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_SHOW: begin
                if (cur_r.blink && !phase_on_r) begin
                    msg_code_s = MSG_BLANK;
                end else begin
                    msg_code_s = cur_r.code;
                end
                if (hold_done_s && !flush) begin
                    pop_s        = !fifo_empty_s;
                    sticky_clr_s = !cur_r.sticky;
                    sticky_set_s = cur_r.sticky && fifo_empty_s;
                end else begin
                    pop_s        = 1'b0;
                    sticky_clr_s = 1'b0;
                    sticky_set_s = 1'b0;
                end
            end
            default: begin
                msg_code_s = IDLE_CODE;
                pop_s      = 1'b0;
            end
        endcase
    end

    // Current entry plus hold/blink timing; a pop restarts timing in the "on" phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_r       <= '{code: 4'd0, blink: 1'b0, sticky: 1'b0};
            hold_cnt_r  <= HOLD_W'(0);
            blink_cnt_r <= BLINK_W'(0);
            phase_on_r  <= 1'b1;
        end else if (flush) begin
            cur_r       <= '{code: 4'd0, blink: 1'b0, sticky: 1'b0};
            hold_cnt_r  <= HOLD_W'(0);
            blink_cnt_r <= BLINK_W'(0);
            phase_on_r  <= 1'b1;
        end else if (pop_s) begin
            cur_r       <= fifo_rdata_s;
            hold_cnt_r  <= HOLD_W'(0);
            blink_cnt_r <= BLINK_W'(0);
            phase_on_r  <= 1'b1;
        end else if ((state_r == ST_SHOW) && !hold_done_s) begin
            cur_r      <= cur_r;
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            if (blink_done_s) begin
                blink_cnt_r <= BLINK_W'(0);
                phase_on_r  <= !phase_on_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
                phase_on_r  <= phase_on_r;
            end
        end else begin
            cur_r       <= cur_r;
            hold_cnt_r  <= HOLD_W'(0);
            blink_cnt_r <= BLINK_W'(0);
            phase_on_r  <= 1'b1;
        end
    end

    // Sticky message memory shown while IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_valid_r <= 1'b0;
            sticky_code_r  <= IDLE_CODE;
        end else if (flush) begin
            sticky_valid_r <= 1'b0;
            sticky_code_r  <= IDLE_CODE;
        end else if (sticky_set_s) begin
            sticky_valid_r <= 1'b1;
            sticky_code_r  <= cur_r.code;
        end else if (sticky_clr_s) begin
            sticky_valid_r <= 1'b0;
            sticky_code_r  <= sticky_code_r;
        end else begin
            sticky_valid_r <= sticky_valid_r;
            sticky_code_r  <= sticky_code_r;
        end
    end

    // Registered outputs to the decoder and status; flush forces idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_code_r <= IDLE_CODE;
            busy_r     <= 1'b0;
            bad_code_r <= 1'b0;
        end else if (flush) begin
            msg_code_r <= msg_safe_code(IDLE_CODE);
            busy_r     <= 1'b0;
            bad_code_r <= 1'b0;
        end else begin
            msg_code_r <= msg_safe_code(msg_code_s);
            busy_r     <= (state_r == ST_SHOW);
            bad_code_r <= handshake_s && (req_code == MSG_INVALID);
        end
    end

endmodule

// File: tb/tb_genius_msg_sequencer.sv
// Randomised and directed bench for genius_msg_sequencer against a timeline
// reference model (queue of requests, elapsed-time display rules).
module tb_genius_msg_sequencer;
    import genius_msg_pkg::*;

    localparam int HOLD  = 8;
    localparam int BLINK = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_blink = 1'b0;
    logic       req_sticky = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] req_code = 4'd0;
    logic       req_ready;
    logic       busy;
    logic       bad_code;
    logic [3:0] msg_code;
    logic [2:0] level;

    always #5 clk = ~clk;

    genius_msg_sequencer #(
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK),
        .FIFO_DEPTH   (DEPTH),
        .IDLE_CODE    (4'd13)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_code   (req_code),
        .req_blink  (req_blink),
        .req_sticky (req_sticky),
        .flush      (flush),
        .msg_code   (msg_code),
        .busy       (busy),
        .bad_code   (bad_code),
        .level      (level)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int code;
        bit blink;
        bit sticky;
    } ent_t;

    ent_t mq[$];
    ent_t m_cur;
    bit   m_show;
    int   m_t;
    bit   m_stk;
    int   m_stk_code;
    int   e_msg, e_busy, e_bad;
    int   accepted;

    function automatic int screen();
        if (m_show) begin
            if (m_cur.blink && (((m_t / BLINK) % 2) == 1)) return 13;
            return m_cur.code;
        end
        return m_stk ? m_stk_code : 13;
    endfunction

    task automatic reset_model();
        mq.delete();
        m_show = 1'b0; m_t = 0; m_stk = 1'b0; m_stk_code = 13;
        e_msg = 13; e_busy = 0; e_bad = 0;
    endtask

    task automatic check_all();
        chk_eq("msg_code", msg_code, e_msg);
        chk_eq("busy", busy, e_busy);
        chk_eq("bad_code", bad_code, e_bad);
        chk_eq("level", level, mq.size());
        chk_eq("req_ready", req_ready, (mq.size() != DEPTH));
    endtask

    // One clock: model consumes the inputs present at the edge, then compare.
    task automatic step();
        bit hs;
        int scr;
        hs  = req_valid && (mq.size() != DEPTH);
        scr = screen();
        @(posedge clk);
        if (flush) begin
            e_msg = 13; e_busy = 0; e_bad = 0;
            mq.delete(); m_show = 1'b0; m_stk = 1'b0;
        end else begin
            e_msg  = scr;
            e_busy = m_show;
            e_bad  = hs && (req_code == 4'd15);
            if (m_show) begin
                m_t++;
                if (m_t == HOLD) begin
                    if (!m_cur.sticky) m_stk = 1'b0;
                    if (mq.size() > 0) begin
                        m_cur = mq.pop_front(); m_t = 0;
                    end else begin
                        if (m_cur.sticky) begin m_stk = 1'b1; m_stk_code = m_cur.code; end
                        m_show = 1'b0;
                    end
                end
            end else if (mq.size() > 0) begin
                m_cur = mq.pop_front(); m_t = 0; m_show = 1'b1;
            end
            if (hs && (req_code != 4'd15)) begin
                mq.push_back('{code: int'(req_code), blink: req_blink, sticky: req_sticky});
                accepted++;
            end
        end
        #1;
        check_all();
    endtask

    task automatic push1(input int code, input bit blink, input bit sticky);
        req_valid = 1'b1; req_code = 4'(code); req_blink = blink; req_sticky = sticky;
        step();
        req_valid = 1'b0; req_blink = 1'b0; req_sticky = 1'b0;
    endtask

    int first, cnt, peak;
    int pat[8];
    int exp_pat[8] = '{9, 9, 13, 13, 9, 9, 13, 13};

    initial begin
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();
        chk_eq("reset_msg", msg_code, 13);
        chk_eq("reset_ready", req_ready, 1);

        // 1: single push of ERRO, two-cycle latency, 8-cycle hold
        push1(8, 1'b0, 1'b0);
        first = -1; cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (msg_code == 4'd8) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        chk_eq("t1_first", first, 2);
        chk_eq("t1_len", cnt, 8);

        // 2: back-to-back pushes, level peaks at 2
        peak = 0;
        req_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            req_code = 4'(c);
            step();
            if (level > peak) peak = level;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (level > peak) peak = level;
        end
        chk_eq("t2_peak", peak, 2);

        // 3: blink pattern
        push1(9, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            pat[i] = msg_code;
        end
        for (int i = 0; i < 8; i++) chk_eq("t3_blink", pat[i], exp_pat[i]);
        step();
        chk_eq("t3_idle", msg_code, 13);

        // 4: sticky, then fill the queue while showing
        push1(6, 1'b0, 1'b1);
        repeat (12) step();
        chk_eq("t4_sticky", msg_code, 6);
        req_valid = 1'b1; req_blink = 1'b0; req_sticky = 1'b0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            req_code = 4'($urandom_range(0, 14));
            step();
        end
        chk_eq("t4_level_full", level, 4);
        chk_eq("t4_ready_low", req_ready, 0);
        chk_eq("t4_accepted", accepted, 5);
        req_valid = 1'b0;
        repeat (45) step();

        // 5: bad code and flush
        push1(15, 1'b0, 1'b0);
        chk_eq("t5_bad_pulse", bad_code, 1);
        step();
        chk_eq("t5_bad_clear", bad_code, 0);
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_code = 4'(i + 1);
            step();
        end
        req_valid = 1'b0;
        step(); step();
        chk_eq("t5_level_pre", level, 3);
        flush = 1'b1; req_valid = 1'b1; req_code = 4'd5;
        step();
        flush = 1'b0; req_valid = 1'b0;
        chk_eq("t5_flush_level", level, 0);
        chk_eq("t5_flush_msg", msg_code, 13);
        step();
        chk_eq("t5_after_msg", msg_code, 13);
        chk_eq("t5_after_level", level, 0);

        // 6: asynchronous reset mid-SHOW
        push1(7, 1'b0, 1'b0);
        push1(3, 1'b0, 1'b0);
        repeat (4) step();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("t6_msg", msg_code, 13);
        chk_eq("t6_level", level, 0);
        chk_eq("t6_busy", busy, 0);
        chk_eq("t6_ready", req_ready, 1);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            req_valid  = ($urandom_range(0, 2) == 0);
            req_code   = 4'($urandom_range(0, 15));
            req_blink  = $urandom_range(0, 1) == 1;
            req_sticky = $urandom_range(0, 2) == 0;
            flush      = ($urandom_range(0, 59) == 0);
            step();
        end
        req_valid = 1'b0; flush = 1'b0;
        repeat (50) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
